// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, 2-flop input synchroniser, mid-bit sampling.
// Optional frame-error pulse output enabled by defining UART_RX_FRAME_ERR_EN.
module uart_rx #(
  parameter int INPUT_CLK = 100000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       rx_frame_err
`endif
);

  // CLKS_PER_BIT must be at least 4 for the half-bit start check to work.
  localparam int CLKS_PER_BIT = INPUT_CLK / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BIT_END  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_END = BAUD_W'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state;
  logic               rx_meta;
  logic               rx_s;
  logic               armed;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;

  // Two-flop synchroniser; idles high so reset never fakes a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with registered outputs and sample timing counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      armed    <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_busy  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      rx_frame_err <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      rx_frame_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          // A held-low line after a bad stop must go high before rearming.
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state    <= START;
            rx_busy  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (baud_cnt == HALF_END) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            state    <= IDLE;
            rx_busy  <= 1'b0;
            armed    <= rx_s;
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end
`ifdef UART_RX_FRAME_ERR_EN
            else begin
              rx_frame_err <= 1'b1;
            end
`endif
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames against a mid-bit sampling model.
// The line waveform is built first, the model derives all expected outputs.
module tb_uart_rx;

  localparam int C = 5;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
`ifdef UART_RX_FRAME_ERR_EN
  logic       rx_frame_err;
`endif

  uart_rx #(.INPUT_CLK(21), .BAUD_RATE(4)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_busy(rx_busy)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .rx_frame_err(rx_frame_err)
`endif
  );

  always #5 clk = ~clk;

  bit         line_q[$];
  bit         rst_q[$];
  bit         e_valid[];
  bit         e_busy[];
  bit         e_ferr[];
  logic [7:0] e_vd[];
  logic [7:0] e_data[];
  logic [7:0] mq[$];
  logic [7:0] dq[$];
  logic [7:0] lit[5];

  int n_chk = 0;
  int n_fail = 0;
  int nt = 0;
  int cyc = 0;
  int t_dir = 0;
  int n_dir = 0;
  int f_dir = 0;
  bit run = 1'b0;

  task automatic put(bit v, bit r);
    line_q.push_back(v);
    rst_q.push_back(r);
  endtask

  task automatic idle(int n);
    repeat (n) put(1'b1, 1'b0);
  endtask

  task automatic frame(logic [7:0] d, bit stop);
    repeat (C) put(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) repeat (C) put(d[i], 1'b0);
    repeat (C) put(stop, 1'b0);
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h",
               nm, cyc, act, exp);
    end
  endtask

  // Line value the receiver decides on at posedge t (2-cycle sync delay).
  function automatic bit rx_at(int t);
    if (t < 4) return 1'b1;
    for (int q = t - 3; q <= t - 1; q++)
      if (rst_q[q]) return 1'b1;
    return line_q[t-3];
  endfunction

  // First posedge in (lo, hi] that sees reset high, else 0.
  function automatic int first_rst(int lo, int hi);
    for (int q = lo + 1; q <= hi; q++)
      if (q - 1 < nt && rst_q[q-1]) return q;
    return 0;
  endfunction

  task automatic run_model();
    int t, te, r;
    bit armed;
    logic [7:0] d, last;
    e_valid = new[nt];
    e_busy  = new[nt];
    e_ferr  = new[nt];
    e_vd    = new[nt];
    e_data  = new[nt];
    t = 1;
    armed = 1'b1;
    while (t < nt) begin
      if (rst_q[t-1]) begin
        armed = 1'b1; t++; continue;
      end
      if (rx_at(t)) begin
        armed = 1'b1; t++; continue;
      end
      if (!armed) begin
        t++; continue;
      end
      te = t + H;
      if (te + 9 * C >= nt) break;
      r = first_rst(t, te);
      if (r != 0) begin
        for (int k = t; k < r; k++) e_busy[k] = 1'b1;
        t = r; continue;
      end
      if (rx_at(te)) begin
        for (int k = t; k < te; k++) e_busy[k] = 1'b1;
        t = te + 1; continue;
      end
      te = t + H + 9 * C;
      r = first_rst(t, te);
      if (r != 0) begin
        for (int k = t; k < r; k++) e_busy[k] = 1'b1;
        t = r; continue;
      end
      for (int k = t; k < te; k++) e_busy[k] = 1'b1;
      for (int i = 0; i < 8; i++) d[i] = rx_at(t + H + C * (i + 1));
      if (rx_at(te)) begin
        e_valid[te] = 1'b1;
        e_vd[te] = d;
        mq.push_back(d);
        if (te < t_dir) n_dir++;
      end else begin
        e_ferr[te] = 1'b1;
        armed = 1'b0;
        if (te < t_dir) f_dir++;
      end
      t = te + 1;
    end
    last = 8'h00;
    for (int k = 1; k < nt; k++) begin
      if (rst_q[k-1]) last = 8'h00;
      if (e_valid[k]) last = e_vd[k];
      e_data[k] = last;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (run && cyc >= 1 && cyc < nt) begin
      logic [7:0] xd;
      bit xv, xb, xf;
      if (rst_q[cyc]) begin
        xd = 8'h00; xv = 1'b0; xb = 1'b0; xf = 1'b0;
      end else begin
        xd = e_data[cyc]; xv = e_valid[cyc];
        xb = e_busy[cyc]; xf = e_ferr[cyc];
      end
      chk("rx_valid", {7'd0, rx_valid}, {7'd0, xv});
      chk("rx_busy", {7'd0, rx_busy}, {7'd0, xb});
      chk("rx_data", rx_data, xd);
`ifdef UART_RX_FRAME_ERR_EN
      chk("rx_frame_err", {7'd0, rx_frame_err}, {7'd0, xf});
`else
      if (xf) n_chk = n_chk + 0;
`endif
      if (rx_valid) dq.push_back(rx_data);
    end
  end

  initial begin
    int s, k;
    lit = '{8'h35, 8'hC3, 8'hAA, 8'h55, 8'h0F};
    repeat (6) put(1'b1, 1'b1);
    idle(10);
    frame(8'h35, 1'b1); idle(10);
    frame(8'hC3, 1'b1); frame(8'hAA, 1'b1); frame(8'h55, 1'b1);
    idle(10);
    put(1'b0, 1'b0); idle(15);
    frame(8'h5A, 1'b0); idle(15);
    s = line_q.size();
    frame(8'hF0, 1'b1);
    for (int i = 1; i <= 3; i++) rst_q[s + 5 * C + i] = 1'b1;
    idle(10);
    frame(8'h0F, 1'b1); idle(10);
    t_dir = line_q.size();
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin
        repeat ($urandom_range(1, 3)) put(1'b0, 1'b0);
        idle(60);
      end else begin
        frame(8'($urandom), k != 1);
        if (k == 1) idle(2 * C);
        idle($urandom_range(0, 3));
      end
    end
    idle(20);
    nt = line_q.size();
    run_model();

    for (int i = 0; i < 5; i++) begin
      if (i < mq.size()) chk("model_byte", mq[i], lit[i]);
      else chk("model_byte_missing", 8'h00, lit[i]);
    end
    chk("model_dir_valids", 8'(n_dir), 8'd5);
    chk("model_dir_ferrs", 8'(f_dir), 8'd1);

    rx = line_q[0];
    reset = rst_q[0];
    run = 1'b1;
    for (int n = 1; n < nt; n++) begin
      @(posedge clk);
      cyc = n;
      #1;
      rx = line_q[n];
      reset = rst_q[n];
    end
    @(posedge clk);
    cyc = nt;
    @(negedge clk);
    run = 1'b0;

    chk("valid_count", 8'(dq.size()), 8'(mq.size()));
    for (int i = 0; i < 5; i++) begin
      if (i < dq.size()) chk("dut_byte", dq[i], lit[i]);
      else chk("dut_byte_missing", 8'h00, lit[i]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter INPUT_CLK, default 100000000, meaning clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, meaning line bit rate in bits/s.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 rx_data  output  8  last correctly framed byte received.
REQ-007 rx_valid  output  1  one-cycle pulse: rx_data newly updated.
REQ-008 rx_busy  output  1  high while a frame is in progress.
REQ-009 rx_frame_err  output  1  one-cycle pulse on a bad stop bit; present only with UART_RX_FRAME_ERR_EN.

Function
REQ-010 Local constant CLKS_PER_BIT SHALL be INPUT_CLK/BAUD_RATE, using integer division, with a minimum legal value of 4.
REQ-011 Local constant HALF_BIT SHALL be CLKS_PER_BIT/2, using integer division.
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-013 The state machine states SHALL be IDLE, START, DATA and STOP.
REQ-014 IDLE: when rx_s = 0, go to START, clear the bit counter and clear the baud counter.
REQ-015 START: after HALF_BIT cycles, sample rx_s.
- If rx_s = 0, go to DATA.
- If rx_s = 1, treat it as a false start, return to IDLE and raise no flag.
REQ-016 DATA: sample rx_s every CLKS_PER_BIT cycles after the previous sample.
- Data is received LSB first into an 8-bit shift register.
- After the 8th sample, go to STOP.
REQ-017 STOP: sample rx_s CLKS_PER_BIT cycles after the 8th data sample.
REQ-018 If the stop sample = 1, the next cycle SHALL load rx_data from the shift register, pulse rx_valid for exactly 1 cycle and return to IDLE.
REQ-019 If the stop sample = 0, rx_data SHALL be left unchanged, rx_valid SHALL NOT pulse, and the FSM SHALL go to IDLE.
- IDLE rearms only once rx_s = 1 has been seen, so a held-low line (break) yields no further frames.
REQ-020 rx_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-021 rx_data SHALL hold its value between rx_valid pulses.
REQ-022 A new start bit SHALL be accepted from the cycle the FSM is back in IDLE, so back-to-back frames (stop bit followed immediately by a start bit) are all received.
REQ-023 The baud counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL never wrap mid-bit.
REQ-024 The bit counter SHALL be 3 bits and roll 7 -> 0 on exit from DATA.

Reset
REQ-025 While reset is high, the FSM SHALL be IDLE and both counters 0.
REQ-026 While reset is high, the synchronizer flops SHALL be 1.
REQ-027 While reset is high, outputs SHALL be rx_data = 8'h00, rx_valid = 0, rx_busy = 0 and rx_frame_err = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no rx_valid pulse.
- After release, reception SHALL resume at the next high-to-low edge of rx_s.

Configuration
REQ-029 Macro UART_RX_FRAME_ERR_EN controls frame-error reporting.
- Defined: port rx_frame_err exists and pulses 1 cycle, in the cycle rx_valid would have pulsed, when the stop sample = 0.
- Undefined: the port and its logic are absent, and the other behaviour is identical.

Verification
All scenarios use INPUT_CLK=21, BAUD_RATE=4, so CLKS_PER_BIT=5 and HALF_BIT=2, with a 10 ns clk and a 50 ns bit period.
REQ-030 Send 8'h35, 8N1 -> rx_data = 8'h35, a single rx_valid pulse, rx_busy high across the frame, no rx_frame_err.
REQ-031 Send 8'hC3, 8'hAA, 8'h55 back-to-back with no idle gap -> three rx_valid pulses carrying C3, AA, 55 in order.
REQ-032 Drive rx low for 1 clk while idle -> no rx_valid, FSM back in IDLE within HALF_BIT+3 cycles.
REQ-033 Send 8'h5A with the stop bit driven 0 -> no rx_valid, rx_data keeps its prior value.
- With UART_RX_FRAME_ERR_EN: one rx_frame_err pulse.
REQ-034 Assert reset during data bit 4 of 8'hF0, release, then send 8'h0F -> only one rx_valid pulse, with rx_data = 8'h0F.
